rtc_reg_sweep_seq: RTL and testbench

Sequencer that walks the RTC register index space and drives the index/enable pair consumed by the register-address decoder, one bus transaction per index. It sits directly upstream of the decoder and beside the RTC bus controller. It issues a one-cycle `bus_go` per index, waits for the controller's `bus_done`, then advances. A read sweep latches the RTC with the transfer command (index 10) first; a write sweep commits with it last.

---
 rtl/rtc_reg_sweep_seq.sv | 180 ++++++++++++++++++
 tb/tb_rtc_reg_sweep_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_reg_sweep_seq.sv
// RTC register sweep sequencer: walks idx through the read/write order, one bus transaction per index.
// Optional per-transaction WAIT timeout with sticky err, enabled by defining RTC_SEQ_TIMEOUT_EN.
module rtc_reg_sweep_seq #(
    parameter int LAST_REG    = 9,
    parameter int CMD_IDX     = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode_rd,
    input  logic       abort,
    input  logic       bus_done,
    output logic [3:0] idx,
    output logic       deco_en,
    output logic       bus_go,
    output logic       bus_rd,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    localparam logic [3:0] LAST_IDX = 4'(LAST_REG);
    localparam logic [3:0] CMD      = 4'(CMD_IDX);

    // The command index must sit outside the data range and everything must fit in 4 bits.
    if (LAST_REG < 0 || LAST_REG > 14 || CMD_IDX <= LAST_REG || CMD_IDX > 15 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rtc_reg_sweep_seq: unsupported parameter combination");
    end

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic       deco_en_reg, deco_en_next;
    logic       bus_go_reg, bus_go_next;
    logic       bus_rd_reg, bus_rd_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       is_last;

`ifdef RTC_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             err_reg, err_next;
`endif

    // Explicit wrap points; the index never rolls over arithmetically.
    function automatic logic [3:0] next_idx(input logic rd, input logic [3:0] cur);
        if (rd) begin
            return (cur == CMD) ? 4'd0 : cur + 4'd1;
        end
        return (cur == LAST_IDX) ? CMD : cur + 4'd1;
    endfunction

    assign is_last = bus_rd_reg ? (idx_reg == LAST_IDX) : (idx_reg == CMD);

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        deco_en_next = deco_en_reg;
        bus_go_next  = 1'b0;
        bus_rd_next  = bus_rd_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_ISSUE;
                    idx_next     = mode_rd ? CMD : 4'd0;
                    deco_en_next = 1'b1;
                    bus_go_next  = 1'b1;
                    bus_rd_next  = mode_rd;
                    busy_next    = 1'b1;
`ifdef RTC_SEQ_TIMEOUT_EN
                    err_next     = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
`ifdef RTC_SEQ_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
            end
            S_WAIT: begin
                if (bus_done) begin
                    if (is_last) begin
                        state_next   = S_FINISH;
                        done_next    = 1'b1;
                        deco_en_next = 1'b0;
                        idx_next     = 4'd0;
                    end else begin
                        state_next  = S_ISSUE;
                        idx_next    = next_idx(bus_rd_reg, idx_reg);
                        bus_go_next = 1'b1;
                    end
                end
`ifdef RTC_SEQ_TIMEOUT_EN
                else if (wait_cnt_reg == CNT_LAST) begin
                    // Give up on an unresponsive controller but still close the sweep with done.
                    state_next   = S_FINISH;
                    done_next    = 1'b1;
                    deco_en_next = 1'b0;
                    idx_next     = 4'd0;
                    err_next     = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
`endif
            end
            S_FINISH: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort && state_reg != S_IDLE) begin
            state_next   = S_IDLE;
            idx_next     = 4'd0;
            deco_en_next = 1'b0;
            bus_go_next  = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
            err_next     = err_reg;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            idx_reg     <= 4'd0;
            deco_en_reg <= 1'b0;
            bus_go_reg  <= 1'b0;
            bus_rd_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            deco_en_reg <= deco_en_next;
            bus_go_reg  <= bus_go_next;
            bus_rd_reg  <= bus_rd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign idx     = idx_reg;
    assign deco_en = deco_en_reg;
    assign bus_go  = bus_go_reg;
    assign bus_rd  = bus_rd_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_rtc_reg_sweep_seq.sv
// Bench for rtc_reg_sweep_seq: a cycle-indexed expected trace built from sweep arithmetic,
// checked every cycle, plus literal checks on recorded DUT activity and an async reset case.
module tb_rtc_reg_sweep_seq;
`ifdef RTC_SEQ_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif
    localparam int MAXC    = 260;
    localparam int RUN_LEN = 248;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, mode_rd = 1'b0, abort = 1'b0, bus_done = 1'b0;
    logic [3:0] idx;
    logic       deco_en, bus_go, bus_rd, busy, done, err;

    rtc_reg_sweep_seq #(.LAST_REG(9), .CMD_IDX(10), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_rd(mode_rd), .abort(abort),
        .bus_done(bus_done), .idx(idx), .deco_en(deco_en), .bus_go(bus_go),
        .bus_rd(bus_rd), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // stimulus sampled at edge c, expected outputs visible in cycle c (after edge c-1)
    bit         s_start[MAXC], s_mode[MAXC], s_abort[MAXC], s_done[MAXC];
    logic [3:0] e_idx[MAXC];
    bit         e_deco[MAXC], e_go[MAXC], e_rd[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC];
    logic [3:0] d_idx[MAXC];
    logic       d_deco[MAXC], d_go[MAXC], d_rd[MAXC], d_busy[MAXC], d_done[MAXC], d_err[MAXC];

    int         checks = 0, errors = 0;
    int         cyc_idx = 0;
    bit         chk_en = 1'b0;
    logic [3:0] go_idx[$];
    int         done_cyc[$];

    int wr_ord[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    int rd_ord[11] = '{10, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    function automatic logic [3:0] order_idx(input bit rd, input int k);
        if (rd) return (k == 0) ? 4'd10 : 4'(k - 1);
        return 4'(k);
    endfunction

    // One sweep starting with start sampled at edge s; each transaction occupies
    // its issue cycle plus d wait cycles, bus_done arriving on the last of them.
    task automatic build_sweep(input int s, input bit rd, input int d,
                               input int abort_k, input int abort_w,
                               input int stall_k, input int stall_t);
        int c;
        s_start[s] = 1'b1;
        s_mode[s]  = rd;
        for (int x = s + 1; x < MAXC; x++) begin
            e_rd[x]  = rd;
            e_err[x] = 1'b0;
        end
        c = s + 1;
        for (int k = 0; k < 11; k++) begin
            int len;
            len = (k == abort_k) ? abort_w : (k == stall_k) ? stall_t : d;
            e_go[c] = 1'b1;
            for (int x = c; x <= c + len; x++) begin
                e_idx[x]  = order_idx(rd, k);
                e_deco[x] = 1'b1;
                e_busy[x] = 1'b1;
            end
            if (k == abort_k) begin
                s_abort[c + len] = 1'b1;
                return;
            end
            if (k == stall_k) begin
                e_done[c + len + 1] = 1'b1;
                e_busy[c + len + 1] = 1'b1;
                for (int x = c + len + 1; x < MAXC; x++) e_err[x] = 1'b1;
                return;
            end
            s_done[c + len] = 1'b1;
            c = c + len + 1;
        end
        e_done[c] = 1'b1;
        e_busy[c] = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " idx"}, 32'(idx), 0);
        chk({tag, " deco_en"}, 32'(deco_en), 0);
        chk({tag, " bus_go"}, 32'(bus_go), 0);
        chk({tag, " bus_rd"}, 32'(bus_rd), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " err"}, 32'(err), 0);
    endtask

    // Single compare process: every cycle of the run against the expected trace.
    always @(negedge clk) begin
        if (chk_en) begin
            d_idx[cyc_idx]  = idx;
            d_deco[cyc_idx] = deco_en;
            d_go[cyc_idx]   = bus_go;
            d_rd[cyc_idx]   = bus_rd;
            d_busy[cyc_idx] = busy;
            d_done[cyc_idx] = done;
            d_err[cyc_idx]  = err;
            if (bus_go === 1'b1) go_idx.push_back(idx);
            if (done === 1'b1) done_cyc.push_back(cyc_idx);
            checks++;
            if (idx !== e_idx[cyc_idx] || deco_en !== e_deco[cyc_idx] || bus_go !== e_go[cyc_idx] ||
                bus_rd !== e_rd[cyc_idx] || busy !== e_busy[cyc_idx] || done !== e_done[cyc_idx] ||
                err !== e_err[cyc_idx]) begin
                errors++;
                $display("FAIL trace cycle %0d: got idx=%0d deco=%b go=%b rd=%b busy=%b done=%b err=%b expected idx=%0d deco=%b go=%b rd=%b busy=%b done=%b err=%b",
                         cyc_idx, idx, deco_en, bus_go, bus_rd, busy, done, err,
                         e_idx[cyc_idx], e_deco[cyc_idx], e_go[cyc_idx], e_rd[cyc_idx],
                         e_busy[cyc_idx], e_done[cyc_idx], e_err[cyc_idx]);
            end
        end
    end

    initial begin
        for (int x = 0; x < MAXC; x++) begin
            e_idx[x] = 4'd0;
        end
        // A: write sweep, bus_done one cycle after each bus_go
        build_sweep(2, 1'b0, 1, -1, 0, -1, 0);
        // B: read sweep, bus_done five cycles after each bus_go
        build_sweep(30, 1'b1, 5, -1, 0, -1, 0);
        // C: write sweep aborted in the WAIT for idx 4
        build_sweep(100, 1'b0, 1, 4, 1, -1, 0);
        // D: restart with abort and start together in IDLE
        build_sweep(114, 1'b0, 1, -1, 0, -1, 0);
        s_abort[114] = 1'b1;
        // E: read sweep with stray start/bus_done that must be ignored
        build_sweep(142, 1'b1, 2, -1, 0, -1, 0);
        s_done[140]  = 1'b1;
        s_done[152]  = 1'b1;
        s_start[147] = 1'b1;
        s_start[176] = 1'b1;
`ifdef RTC_SEQ_TIMEOUT_EN
        // F: bus_done withheld at idx 2
        build_sweep(180, 1'b0, 1, -1, 0, 2, TB_TO);
`endif
        // G: plain write sweep (clears err when the timeout build is in use)
        build_sweep(200, 1'b0, 1, -1, 0, -1, 0);
        // H: write sweep, run stops in the WAIT for idx 7
        build_sweep(232, 1'b0, 1, -1, 0, -1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < RUN_LEN; k++) begin
            start    = s_start[k];
            mode_rd  = s_mode[k];
            abort    = s_abort[k];
            bus_done = s_done[k];
            @(posedge clk);
            #1;
            cyc_idx = k + 1;
            chk_en  = 1'b1;
        end
        start = 1'b0; mode_rd = 1'b0; abort = 1'b0; bus_done = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        // literal expectations
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("write order %0d", i), (go_idx.size() > i) ? 32'(go_idx[i]) : 32'hFFFF, 32'(wr_ord[i]));
            chk($sformatf("read order %0d", i), (go_idx.size() > 11 + i) ? 32'(go_idx[11 + i]) : 32'hFFFF, 32'(rd_ord[i]));
        end
        chk("first bus_go cycle", 32'(d_go[3]), 1);
        chk("first busy", 32'(d_busy[3]), 1);
        chk("write done cycle", 32'(d_done[25]), 1);
        chk("busy in finish", 32'(d_busy[25]), 1);
        chk("busy drop", 32'(d_busy[26]), 0);
        chk("read bus_rd", 32'(d_rd[40]), 1);
        chk("read done cycle", 32'(d_done[97]), 1);
        chk("abort idx before", 32'(d_idx[110]), 4);
        chk("abort idx", 32'(d_idx[111]), 0);
        chk("abort deco_en", 32'(d_deco[111]), 0);
        chk("abort busy", 32'(d_busy[111]), 0);
        chk("restart go", 32'(d_go[115]), 1);
        chk("restart idx", 32'(d_idx[115]), 0);
        chk("stray sweep done", 32'(d_done[176]), 1);
        chk("stray sweep rd held", 32'(d_rd[178]), 1);
        chk("wait idx7", 32'(d_idx[248]), 7);
`ifdef RTC_SEQ_TIMEOUT_EN
        chk("bus_go count", 32'(go_idx.size()), 71);
        chk("done count", 32'(done_cyc.size()), 6);
        chk("timeout done", 32'(d_done[194]), 1);
        chk("timeout err", 32'(d_err[194]), 1);
        chk("err sticky", 32'(d_err[200]), 1);
        chk("err cleared", 32'(d_err[201]), 0);
`else
        chk("bus_go count", 32'(go_idx.size()), 68);
        chk("done count", 32'(done_cyc.size()), 5);
        chk("err tied", 32'(d_err[194]), 0);
`endif
        chk("last done cycle", (done_cyc.size() > 0) ? 32'(done_cyc[done_cyc.size() - 1]) : 32'hFFFF, 223);

        // asynchronous reset in the middle of the WAIT for idx 7
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle after reset busy", 32'(busy), 0);
        chk("idle after reset go", 32'(bus_go), 0);
        start = 1'b1;
        mode_rd = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("post reset go", 32'(bus_go), 1);
        chk("post reset idx", 32'(idx), 0);
        chk("post reset busy", 32'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
